// File: rtl/rids_merge_scheduler_pkg.sv
// Shared definitions for the RIDS merge scheduler.
//   NUM_RIDS   : rule-ID sets per packet (1..16)
//   NUM_RID    : rule-ID slots per RIDS
//   RID_WIDTH  : bits per rule ID
//   RIDS_WIDTH : bits per RIDS
//   MERGE_LAT  : cycles from merge_start to a valid merge_res (>= 1)
// Slot i of a RIDS occupies [i*RID_WIDTH +: RID_WIDTH]; RIDS#k of a bundle
// occupies [k*RIDS_WIDTH +: RIDS_WIDTH].
package rids_merge_scheduler_pkg;

  localparam int NUM_RIDS   = 5;
  localparam int NUM_RID    = 8;
  localparam int RID_WIDTH  = 4;
  localparam int RIDS_WIDTH = NUM_RID * RID_WIDTH;
  localparam int MERGE_LAT  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rids_merge_scheduler_reverse.sv
// rids_reverse: reverses the rule-ID slot order of one RIDS so that an
// ascending operand and a reversed operand form a bitonic pair.
//   rids_i : input RIDS
//   rids_o : slot i = rids_i slot N_SLOT-1-i
module rids_reverse
  import rids_merge_scheduler_pkg::*;
#(
  parameter int N_SLOT = NUM_RID,
  parameter int SLOT_W = RID_WIDTH
) (
  input  logic [N_SLOT*SLOT_W-1:0] rids_i,
  output logic [N_SLOT*SLOT_W-1:0] rids_o
);

  for (genvar i = 0; i < N_SLOT; i++) begin : g_slot
    assign rids_o[i*SLOT_W +: SLOT_W] = rids_i[(N_SLOT-1-i)*SLOT_W +: SLOT_W];
  end

endmodule

// File: rtl/rids_merge_scheduler.sv
// rids_merge_scheduler: folds a bundle of N_RIDS rule-ID sets through one
// shared fixed-latency merge unit: acc = RIDS#0, then
// acc = merge(acc, reverse(RIDS#k)) for k = 1..N_RIDS-1.
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_ready : bundle handshake, in_rids holds N_RIDS RIDS
//   merge_start       : one-cycle issue strobe to the merge unit
//   merge_a/merge_b   : accumulator / reversed RIDS#k operands
//   merge_res         : merge result, valid M_LAT cycles after merge_start
//   out_valid/out_ready, out_rids : final merged RIDS handshake
//   busy              : high in every state except IDLE
module rids_merge_scheduler
  import rids_merge_scheduler_pkg::*;
#(
  parameter int N_RIDS = NUM_RIDS,
  parameter int M_LAT  = MERGE_LAT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_RIDS*RIDS_WIDTH-1:0] in_rids,
  output logic                         merge_start,
  output logic [RIDS_WIDTH-1:0]        merge_a,
  output logic [RIDS_WIDTH-1:0]        merge_b,
  input  logic [RIDS_WIDTH-1:0]        merge_res,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RIDS_WIDTH-1:0]        out_rids,
  output logic                         busy
);

  localparam int KW = $clog2(N_RIDS) + 1;
  localparam int CW = (M_LAT > 1) ? $clog2(M_LAT) : 1;

  state_e                state_q;
  logic [KW-1:0]         k_q;
  logic [CW-1:0]         cnt_q;
  logic                  in_ready_q;
  logic                  merge_start_q;
  logic [RIDS_WIDTH-1:0] merge_a_q;     // doubles as the accumulator
  logic [RIDS_WIDTH-1:0] merge_b_q;
  logic                  out_valid_q;
  logic [RIDS_WIDTH-1:0] out_rids_q;
  logic                  busy_q;
  logic [RIDS_WIDTH-1:0] rids_q [N_RIDS];
  logic [RIDS_WIDTH-1:0] sel_rids_d;
  logic [RIDS_WIDTH-1:0] rev_rids;

  // NOTE: captured bundle storage carries no reset; it is only read after a
  // fresh capture, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && in_valid) begin
      for (int j = 0; j < N_RIDS; j++) begin
        rids_q[j] <= in_rids[j*RIDS_WIDTH +: RIDS_WIDTH];
      end
    end
  end

  // Operand for the next issue: RIDS#1 straight from the input on accept,
  // otherwise RIDS#(k+1) from the captured bundle.
  // NOTE: default assignment first so no path through the loop infers a latch.
  always_comb begin
    sel_rids_d = '0;
    for (int j = 0; j < N_RIDS; j++) begin
      if (state_q == ST_IDLE) begin
        if (j == 1) sel_rids_d = in_rids[j*RIDS_WIDTH +: RIDS_WIDTH];
      end else if (j == int'(k_q) + 1) begin
        sel_rids_d = rids_q[j];
      end
    end
  end

  rids_reverse #(
    .N_SLOT (NUM_RID),
    .SLOT_W (RID_WIDTH)
  ) u_reverse (
    .rids_i (sel_rids_d),
    .rids_o (rev_rids)
  );

  // Outputs are registered: each is loaded on the edge that enters the state
  // in which it must be visible, so merge_start is high exactly in ISSUE.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      cnt_q         <= '0;
      in_ready_q    <= 1'b1;
      merge_start_q <= 1'b0;
      merge_a_q     <= '0;
      merge_b_q     <= '0;
      out_valid_q   <= 1'b0;
      out_rids_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      merge_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (N_RIDS == 1) begin
              out_rids_q  <= in_rids[RIDS_WIDTH-1:0];
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              merge_a_q     <= in_rids[RIDS_WIDTH-1:0];
              merge_b_q     <= rev_rids;
              merge_start_q <= 1'b1;
              k_q           <= KW'(1);
              state_q       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cnt_q   <= CW'(M_LAT - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            // merge_res is valid only in this cycle
            if (k_q == KW'(N_RIDS - 1)) begin
              out_rids_q  <= merge_res;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              merge_a_q     <= merge_res;
              merge_b_q     <= rev_rids;
              merge_start_q <= 1'b1;
              k_q           <= k_q + KW'(1);
              state_q       <= ST_ISSUE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign merge_start = merge_start_q;
  assign merge_a     = merge_a_q;
  assign merge_b     = merge_b_q;
  assign out_valid   = out_valid_q;
  assign out_rids    = out_rids_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rids_merge_scheduler.sv
// Directed bench for rids_merge_scheduler: a default build (5 RIDS, latency 4)
// against a min-per-slot merge model, plus a single-RIDS build.
module tb_rids_merge_scheduler;
  import rids_merge_scheduler_pkg::*;

  localparam int W = RIDS_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  in_valid, in_ready, merge_start, out_valid, out_ready, busy;
  logic [NUM_RIDS*W-1:0] in_rids;
  logic [W-1:0]          merge_a, merge_b, merge_res, out_rids;

  logic         in1_valid, in1_ready, merge1_start, out1_valid, out1_ready, busy1;
  logic [W-1:0] in1_rids, merge1_a, merge1_b, out1_rids;

  rids_merge_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rids     (in_rids),
    .merge_start (merge_start),
    .merge_a     (merge_a),
    .merge_b     (merge_b),
    .merge_res   (merge_res),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rids    (out_rids),
    .busy        (busy)
  );

  rids_merge_scheduler #(.N_RIDS(1)) dut1 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in1_valid),
    .in_ready    (in1_ready),
    .in_rids     (in1_rids),
    .merge_start (merge1_start),
    .merge_a     (merge1_a),
    .merge_b     (merge1_b),
    .merge_res   (32'hA5A5_A5A5),
    .out_valid   (out1_valid),
    .out_ready   (out1_ready),
    .out_rids    (out1_rids),
    .busy        (busy1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Merge unit model: elementwise min, valid MERGE_LAT cycles after start,
  // garbage otherwise so a mistimed sample corrupts the result.
  function automatic logic [W-1:0] slot_min(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_RID; i++) begin
      r[i*RID_WIDTH +: RID_WIDTH] = (a[i*RID_WIDTH +: RID_WIDTH] < b[i*RID_WIDTH +: RID_WIDTH]) ?
                                    a[i*RID_WIDTH +: RID_WIDTH] : b[i*RID_WIDTH +: RID_WIDTH];
    end
    return r;
  endfunction

  bit [W-1:0] pipe [MERGE_LAT];
  bit         vld  [MERGE_LAT];
  always @(posedge clk) begin
    pipe[0] <= slot_min(merge_a, merge_b);
    vld[0]  <= (merge_start === 1'b1);
    for (int i = 1; i < MERGE_LAT; i++) begin
      pipe[i] <= pipe[i-1];
      vld[i]  <= vld[i-1];
    end
  end
  assign merge_res = vld[MERGE_LAT-1] ? pipe[MERGE_LAT-1] : 32'hA5A5_A5A5;

  // merge_start monitors
  int           starts[$];
  logic [W-1:0] first_b;
  int           starts1_cnt = 0;
  always @(negedge clk) begin
    if (merge_start === 1'b1) begin
      if (starts.size() == 0) first_b = merge_b;
      starts.push_back(cyc);
    end
    if (merge1_start === 1'b1) starts1_cnt++;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},    in_ready,    1'b1);
    check({tag, "_busy"},        busy,        1'b0);
    check({tag, "_out_valid"},   out_valid,   1'b0);
    check({tag, "_out_rids"},    out_rids,    '0);
    check({tag, "_merge_start"}, merge_start, 1'b0);
    check({tag, "_merge_a"},     merge_a,     '0);
    check({tag, "_merge_b"},     merge_b,     '0);
  endtask

  // Accept one bundle now, optionally poke in_valid at T+5, check issue
  // timing and result, stall the output, then hand it off.
  task automatic do_bundle(input string tag, input logic [NUM_RIDS*W-1:0] data,
                           input bit poke, input int stall, input logic [W-1:0] exp_out,
                           input bit chk_b, input logic [W-1:0] exp_b);
    int t0;
    int rise;
    check({tag, "_in_ready_pre"}, in_ready, 1'b1);
    starts.delete();
    in_valid = 1'b1;
    in_rids  = data;
    t0       = cyc;
    step();
    in_valid = 1'b0;
    in_rids  = '0;
    check({tag, "_ready_busy_T1"}, {in_ready, busy}, 2'b01);
    rise = -1;
    for (int i = 0; i < 60; i++) begin
      if (out_valid === 1'b1) begin
        rise = cyc;
        break;
      end
      in_valid = poke && (cyc == t0 + 5);
      in_rids  = in_valid ? '0 : data;
      step();
    end
    in_valid = 1'b0;
    check({tag, "_out_valid_cycle"}, rise, t0 + 1 + (NUM_RIDS-1)*(MERGE_LAT+1));
    check({tag, "_num_starts"}, starts.size(), NUM_RIDS - 1);
    for (int k = 0; k < NUM_RIDS - 1; k++) begin
      check({tag, "_start_cycle"}, (k < starts.size()) ? starts[k] : -1, t0 + 1 + k*(MERGE_LAT+1));
    end
    check({tag, "_out_rids"}, out_rids, exp_out);
    if (chk_b) check({tag, "_merge_b_k1"}, first_b, exp_b);
    for (int i = 0; i < stall; i++) begin
      step();
      check({tag, "_stall_rids"}, out_rids, exp_out);
      check({tag, "_stall_flags"}, {out_valid, in_ready, busy}, 3'b101);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle_after"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  localparam logic [NUM_RIDS*W-1:0] BUNDLE_A =
    {32'h3333_3333, 32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};
  localparam logic [NUM_RIDS*W-1:0] BUNDLE_B =
    {32'h3333_3333, 32'h4444_4444, 32'h5555_5555, 32'h7654_3210, 32'h7777_7777};

  initial begin
    int t0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_rids    = '0;
    out_ready  = 1'b0;
    in1_valid  = 1'b0;
    in1_rids   = '0;
    out1_ready = 1'b0;
    repeat (3) step();
    check_reset_vals("reset");
    reset = 1'b0;
    step();
    step();
    check("idle_no_start", starts.size(), 0);
    check_reset_vals("idle");

    // uniform slots 7,6,5,4,3 -> all 3; stalled output then back-to-back
    do_bundle("basic", BUNDLE_A, 1'b0, 10, 32'h3333_3333, 1'b0, '0);
    // in_valid toggled with zero data while busy must be ignored
    do_bundle("busy_in", BUNDLE_A, 1'b1, 0, 32'h3333_3333, 1'b0, '0);
    // RIDS#1 slot i = i: merge_b for k=1 has slot i = 7-i
    do_bundle("reverse", BUNDLE_B, 1'b0, 0, 32'h0123_3333, 1'b1, 32'h0123_4567);

    // reset at T+8 aborts the bundle; a fresh one follows immediately
    in_valid = 1'b1;
    in_rids  = BUNDLE_A;
    t0       = cyc;
    step();
    in_valid = 1'b0;
    while (cyc < t0 + 8) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_vals("abort");
    do_bundle("after_reset", BUNDLE_B, 1'b0, 2, 32'h0123_3333, 1'b1, 32'h0123_4567);

    // single-RIDS build passes RIDS#0 straight through
    check("n1_in_ready", in1_ready, 1'b1);
    in1_valid = 1'b1;
    in1_rids  = 32'h0123_4567;
    step();
    in1_valid = 1'b0;
    in1_rids  = '0;
    check("n1_out_valid", out1_valid, 1'b1);
    check("n1_out_rids", out1_rids, 32'h0123_4567);
    check("n1_ready_busy", {in1_ready, busy1}, 2'b01);
    out1_ready = 1'b1;
    step();
    out1_ready = 1'b0;
    check("n1_idle_after", {out1_valid, in1_ready, busy1}, 3'b010);
    check("n1_no_start", starts1_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
